// File: rtl/mult_arbiter.sv
// Round-robin front end that time-shares one start/done sequential multiplier
// among NREQ requesters, with a watchdog that aborts a stalled multiply.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic                  rsp_err,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] last;
  logic [IDW-1:0] pick;
  logic           pick_valid;
  logic [WDW-1:0] wdog;
  logic           wdog_expired;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  // Rotating priority: the search starts at the requester after the last one served.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_valid && req_valid[wrap_idx(last, k)]) begin
        pick_valid = 1'b1;
        pick       = wrap_idx(last, k);
      end
    end
  end

  assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mul_done || wdog_expired) state_next = RESP;
      RESP:    if (rsp_ready[grant_id]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && pick_valid) req_ready[pick] = 1'b1;
    if (state == RESP) rsp_valid[grant_id] = 1'b1;
    mul_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // Operands stay frozen from the grant until the next grant, so they are stable while the multiplier runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      grant_id <= '0;
      last     <= IDW'(NREQ - 1);
      wdog     <= '0;
      rsp_p    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mul_a    <= req_a[pick*WIDTH +: WIDTH];
            mul_b    <= req_b[pick*WIDTH +: WIDTH];
            grant_id <= pick;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          wdog <= wdog + WDW'(1);
          if (mul_done) begin
            rsp_p   <= mul_p;
            rsp_err <= 1'b0;
          end else if (wdog_expired) begin
            rsp_p   <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: if (rsp_ready[grant_id]) last <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one sequential signed multiplier (start/done style, e.g. the SeqMult family) between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake, launches the multiplier, and waits for completion under a watchdog. It then returns the 2*WIDTH product to the granted requester. It sits between the client blocks and the single multiplier instance in the datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; product is 2*WIDTH
- TIMEOUT, 256, max cycles waited for mul_done before aborting
- IDW, $clog2(NREQ), requester index width (derived)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*WIDTH  signed operand A; slice i belongs to requester i
- req_b  in  NREQ*WIDTH  signed operand B; slice i belongs to requester i
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot response valid
- rsp_p  out  2*WIDTH  signed product, shared by all requesters
- rsp_err  out  1  response is a timeout abort; rsp_p is 0
- rsp_ready  in  NREQ  per-requester response accept
- mul_start  out  1  one-cycle launch pulse to the multiplier
- mul_a, mul_b  out  WIDTH each  operands to the multiplier; stable from ISSUE until leaving WAIT
- mul_done  in  1  multiplier completion pulse
- mul_p  in  2*WIDTH  multiplier product, valid while mul_done is high
- busy  out  1  high in every state except IDLE
- grant_id  out  IDW  index of the current or last granted requester

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, choose g = the first valid index searching upward, with wrap, from last+1.
  - Assert req_ready[g] combinationally in that cycle, latch req_a[g], req_b[g] into mul_a, mul_b, and set grant_id = g.
  - Next state: ISSUE.
- ISSUE: mul_start = 1 for exactly this cycle, clear the watchdog counter, go to WAIT.
- WAIT:
  - Watchdog increments every cycle.
  - If mul_done: latch mul_p into rsp_p, rsp_err = 0, go to RESP.
  - Else if watchdog reaches TIMEOUT-1: rsp_p = 0, rsp_err = 1, go to RESP.
  - mul_done takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid[g] = 1, with rsp_p and rsp_err held stable.
  - When rsp_ready[g] is high: update last = g and go to IDLE.
  - rsp_ready on any other index is ignored.
- Response handling:
  - mul_done is ignored outside WAIT.
  - Only one transaction is outstanding at a time.
  - No new grant is issued until the response has been accepted.
- Requesters must hold req_valid and their operands until req_ready. A req_valid drop before grant is legal and simply withdraws the request.
- Arithmetic: no width conversion. rsp_p is mul_p passed through bit-exact, two's complement.
- Reset (rst low, asynchronous):
  - State returns to IDLE; last = NREQ-1, so requester 0 has first priority.
  - All outputs go to 0: req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b, busy, grant_id.
  - The watchdog clears.
  - Reset mid-WAIT abandons the transaction; a late mul_done after release is ignored because the FSM is in IDLE.

## Timing
- Request granted in cycle t (req_ready high).
- mul_start is high in cycle t+1.
- If mul_done arrives in cycle t+1+k (k ≥ 1), rsp_valid rises in cycle t+2+k.
- With rsp_ready already high, the earliest next grant is cycle t+3+k.
- Timeout path: rsp_valid with rsp_err rises exactly TIMEOUT+2 cycles after the grant.
- busy rises in cycle t+1 and falls in the cycle after the rsp handshake.
- At most one bit of req_ready and at most one bit of rsp_valid is high in any cycle.

## Test plan
- Single request on requester 1, A=10, B=-150, multiplier done after 33 cycles. Required: rsp_valid[1] with rsp_p=-1500 and rsp_err=0; mul_start pulses exactly once, 1 cycle after the grant.
- Requesters 0 and 2 valid together after reset, (-10 x -150) and (-150 x 150). Required: 0 is served first with 1500, then 2 with -22500; grant order is 0, 2.
- All 4 requesters permanently valid (operand pairs 0x150, 1x150, 10x22, 2x4). Required: grant sequence 0,1,2,3,0,1; products 0, 150, 220, 8.
- rsp_ready[0] held low 20 cycles in RESP. Required: rsp_valid[0] and rsp_p stay stable; no req_ready is asserted; busy=1 throughout.
- mul_done never asserted, TIMEOUT=16. Required: rsp_err=1 and rsp_p=0, 18 cycles after the grant; the next request proceeds normally.
- rst asserted low in WAIT, then a mul_done pulse arrives after release. Required: every output is 0 immediately after reset (asynchronous); the late mul_done is ignored; the first later grant goes to requester 0 when all are valid.
